spi_master_core: RTL and testbench

SPI_MASTER_CORE -- requirements
Module: spi_master_core

---
 rtl/spi_master_core.sv | 155 +++++++++++++++
 tb/tb_spi_master_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI mode-0 master: one DATA_WIDTH-bit full-duplex transfer per start, paced by a slow tick_in level.
// Define SPI_LSB_FIRST_EN to shift LSB-first in both directions (MSB-first otherwise).
module spi_master_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic first_out(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_WIDTH-1];
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, w[DATA_WIDTH-1:1]};
`else
    return {w[DATA_WIDTH-2:0], b};
`endif
  endfunction

  state_e                  state_q;
  logic [2:0]              sync_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic [CW-1:0]           cnt_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic                    cs_n_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tick_s;
  logic [DATA_WIDTH-1:0]   tx_shift_d;

  // Two flops resynchronise tick_in; the third only remembers the previous level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], tick_in};
    end
  end

  assign tick_s     = sync_q[1] & ~sync_q[2];
  assign tx_shift_d = tx_shift(tx_q);

  // Transfer sequencer; every output is a flop so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Ticks arriving here are dropped, so a tick coincident with start never moves sclk.
          if (start) begin
            tx_q    <= tx_data;
            cnt_q   <= '0;
            mosi_q  <= first_out(tx_data);
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (tick_s) begin
            sclk_q  <= 1'b1;
            rx_q    <= rx_shift(rx_q, miso);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
              tx_q   <= tx_shift_d;
              mosi_q <= first_out(tx_shift_d);
              cnt_q  <= cnt_q + CW'(1);
              if (cnt_q == LAST_BIT) begin
                state_q <= HOLD;
              end
            end else begin
              sclk_q <= 1'b1;
              rx_q   <= rx_shift(rx_q, miso);
            end
          end
        end
        HOLD: begin
          if (tick_s) begin
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            rx_data_q <= rx_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: directed and random transfers against a bit-order word model.
// Honours SPI_LSB_FIRST_EN the same way the design does.
module tb_spi_master_core;

  localparam int W     = 8;
  localparam int NTICK = 2 * W + 1;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         tick_in  = 1'b0;
  logic         start    = 1'b0;
  logic         miso_drv = 1'b0;
  logic         loop_en  = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         miso;
  logic         sclk, mosi, cs_n, busy, done;
  logic [W-1:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_total = 0;
  int done_total = 0;
  int mosi_one_total = 0;
  logic mosi_bits [0:4095];
  logic sclk_prev = 1'b0;
  logic [W-1:0] exp_rx_last = '0;

  assign miso = loop_en ? mosi : miso_drv;

  spi_master_core #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .tx_data(tx_data),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
    .done(done), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // Serial position k of a word maps to this bit index.
  function automatic int ser_idx(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return W - 1 - k;
`endif
  endfunction

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev === 1'b0 && rise_total < 4096) begin
      mosi_bits[rise_total] = mosi;
      rise_total++;
    end
    if (done === 1'b1) done_total++;
    if (cs_n === 1'b0 && mosi === 1'b1) mosi_one_total++;
    sclk_prev = sclk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // One tick_in period: 4 clk high, 4 clk low; optionally chains a start the clk after done.
  task automatic tick_pulse(input bit chain, input logic [W-1:0] chain_tx, inout bit chained);
    tick_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) tick_in = 1'b0;
      if (chain && !chained && done === 1'b1) begin
        start   = 1'b1;
        tx_data = chain_tx;
        chained = 1'b1;
      end
    end
  endtask

  task automatic do_transfer(input string name, input logic [W-1:0] tx, input bit loop,
                             input logic [W-1:0] rxpat, input bit skip_start, input bit chain,
                             input logic [W-1:0] chain_tx, input int restart_at, input int stall_at);
    int rbase, dbase, obase, done_tick, k, dsave;
    bit cs_ok, rx_ok, chained;
    logic s_sv, c_sv, b_sv;
    logic [W-1:0] exp_rx, mw;
    loop_en = loop;
    exp_rx  = loop ? tx : rxpat;
    rbase = rise_total; dbase = done_total; obase = mosi_one_total;
    if (!skip_start) begin
      @(negedge clk);
      tx_data = tx; start = 1'b1;
      @(negedge clk);
      start = 1'b0; tx_data = W'($urandom);
    end
    n_checks++;
    if ({busy, cs_n, sclk} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s accept: busy,cs_n,sclk=%b required 100", name, {busy, cs_n, sclk});
    end
    done_tick = 0; cs_ok = 1'b1; rx_ok = 1'b1; chained = 1'b0;
    for (int i = 1; i <= NTICK + 3 && done_tick == 0; i++) begin
      k = rise_total - rbase;
      if (k < W) miso_drv = rxpat[ser_idx(k)];
      tick_pulse(chain, chain_tx, chained);
      if (done_total != dbase) begin
        done_tick = i;
      end else begin
        if (cs_n !== 1'b0) cs_ok = 1'b0;
        if (rx_data !== exp_rx_last) rx_ok = 1'b0;
      end
      if (i == restart_at) begin
        tx_data = W'(8'h3C); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == stall_at) begin
        s_sv = sclk; c_sv = cs_n; b_sv = busy; dsave = done_total;
        repeat (300) @(negedge clk);
        n_checks++;
        if ({sclk, cs_n, busy} !== {s_sv, c_sv, b_sv} || done_total != dsave) begin
          n_fail++;
          $display("FAIL %s stall: sclk,cs_n,busy=%b dones=%0d required %b dones=%0d",
                   name, {sclk, cs_n, busy}, done_total, {s_sv, c_sv, b_sv}, dsave);
        end
      end
    end
    n_checks++;
    if (done_tick != NTICK) begin
      n_fail++;
      $display("FAIL %s done_tick: got %0d required %0d", name, done_tick, NTICK);
    end
    n_checks++;
    if (done_total - dbase != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d required 1", name, done_total - dbase);
    end
    n_checks++;
    if (rise_total - rbase != W) begin
      n_fail++;
      $display("FAIL %s sclk_rises: got %0d required %0d", name, rise_total - rbase, W);
    end
    mw = '0;
    for (int j = 0; j < W; j++) mw[ser_idx(j)] = mosi_bits[rbase + j];
    n_checks++;
    if (mw !== tx) begin
      n_fail++;
      $display("FAIL %s mosi_stream: got %h required %h", name, mw, tx);
    end
    n_checks++;
    if (rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL %s rx_data: got %h required %h", name, rx_data, exp_rx);
    end
    n_checks++;
    if (!cs_ok || !rx_ok) begin
      n_fail++;
      $display("FAIL %s hold: cs_low_ok=%0d rx_hold_ok=%0d required 1 1", name, cs_ok, rx_ok);
    end
    if (tx == '0) begin
      n_checks++;
      if (mosi_one_total != obase) begin
        n_fail++;
        $display("FAIL %s mosi_zero: %0d cycles with mosi=1, required 0", name, mosi_one_total - obase);
      end
    end
    n_checks++;
    if (chain) begin
      if ({busy, cs_n} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s chain_start: busy,cs_n=%b required 10", name, {busy, cs_n});
      end
    end else if ({cs_n, busy, sclk, mosi} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s idle_after: cs_n,busy,sclk,mosi=%b required 1000", name, {cs_n, busy, sclk, mosi});
    end
    exp_rx_last = exp_rx;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sclk, mosi, cs_n, busy, done} !== 5'b00100 || rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: sclk,mosi,cs_n,busy,done=%b rx=%h required 00100 rx=00",
               {sclk, mosi, cs_n, busy, done}, rx_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    do_transfer("loop_a5", W'(8'hA5), 1'b1, '0, 1'b0, 1'b0, '0, 0, 0);
    do_transfer("loop_01", W'(8'h01), 1'b1, '0, 1'b0, 1'b0, '0, 0, 0);
  endtask

  task automatic test_miso_ones();
    do_transfer("miso_ones", W'(8'h00), 1'b0, W'(8'hFF), 1'b0, 1'b0, '0, 0, 0);
  endtask

  task automatic test_ignore_start();
    do_transfer("ignore_start", W'(8'hA5), 1'b1, '0, 1'b0, 1'b0, '0, 5, 0);
  endtask

  task automatic test_stall();
    do_transfer("stall", W'($urandom), 1'b0, W'($urandom), 1'b0, 1'b0, '0, 0, 6);
  endtask

  task automatic test_reset_mid();
    int rb, db;
    bit dummy;
    loop_en = 1'b1; dummy = 1'b0;
    @(negedge clk);
    tx_data = W'(8'hA5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rb = rise_total; db = done_total;
    for (int i = 0; i < 10 && rise_total - rb < 3; i++) tick_pulse(1'b0, '0, dummy);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sclk, busy, done, mosi} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid: cs_n,sclk,busy,done,mosi=%b required 10000", {cs_n, sclk, busy, done, mosi});
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_total != db || rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: dones=%0d rx=%h required %0d rx=00", done_total - db, rx_data, 0);
    end
    exp_rx_last = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_transfer("after_reset_5a", W'(8'h5A), 1'b1, '0, 1'b0, 1'b0, '0, 0, 0);
  endtask

  task automatic test_coincident_tick();
    logic [W-1:0] tx;
    tx = W'($urandom);
    loop_en = 1'b1;
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({sclk, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coincident_tick: sclk,busy=%b required 01", {sclk, busy});
    end
    do_transfer("coincident_xfer", tx, 1'b1, '0, 1'b1, 1'b0, '0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int db;
    db = done_total;
    do_transfer("b2b_first", W'(8'hA5), 1'b1, '0, 1'b0, 1'b1, W'(8'hFF), 0, 0);
    do_transfer("b2b_second", W'(8'hFF), 1'b1, '0, 1'b1, 1'b0, '0, 0, 0);
    n_checks++;
    if (done_total - db != 2) begin
      n_fail++;
      $display("FAIL b2b_dones: got %0d required 2", done_total - db);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++)
      do_transfer("random", W'($urandom), 1'($urandom_range(1, 0)), W'($urandom), 1'b0, 1'b0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_ones();
    test_ignore_start();
    test_stall();
    test_reset_mid();
    test_coincident_tick();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
